// File: rtl/srload_pkg.sv
// Shared types and sizing constants for the shift-register load sequencer.
// Register lengths match the generator; the counter is wide enough for the longer one.
package srload_pkg;

  localparam int SIZESRSTAT_DEF = 88;
  localparam int SIZESRDYN_DEF  = 16;

  function automatic int cnt_width(input int len_a, input int len_b);
    return $clog2((len_a > len_b) ? len_a : len_b);
  endfunction

  localparam int CNT_W = cnt_width(SIZESRSTAT_DEF, SIZESRDYN_DEF);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_DYN  = 2'd1,
    SHIFT_STAT = 2'd2,
    LATCH      = 2'd3
  } srload_state_t;

  typedef enum logic {
    DYN  = 1'b0,
    STAT = 1'b1
  } srload_grant_t;

endpackage

// File: rtl/srload_if.sv
// Request/ack handshake plus the serial link to the generator's shift registers.
// master = requester side (uC register block), slave = the sequencer.
interface srload_if
  import srload_pkg::*;
#(
  parameter int SIZESRSTAT = SIZESRSTAT_DEF,
  parameter int SIZESRDYN  = SIZESRDYN_DEF
) ();

  logic                  stat_req;
  logic [SIZESRSTAT-1:0] stat_data;
  logic                  dyn_req;
  logic [SIZESRDYN-1:0]  dyn_data;
  logic                  stat_ack;
  logic                  dyn_ack;
  logic                  SELSTAT;
  logic                  SELDYN;
  logic                  SDATA;
  logic                  LATCH_STAT;
  logic                  LATCH_DYN;
  logic                  busy;

  modport master (
    output stat_req, stat_data, dyn_req, dyn_data,
    input  stat_ack, dyn_ack, SELSTAT, SELDYN, SDATA, LATCH_STAT, LATCH_DYN, busy
  );

  modport slave (
    input  stat_req, stat_data, dyn_req, dyn_data,
    output stat_ack, dyn_ack, SELSTAT, SELDYN, SDATA, LATCH_STAT, LATCH_DYN, busy
  );

endinterface

// File: rtl/srload_serializer.sv
// Single MSB-first shifter shared by both words, with a bit down-counter.
// Words are loaded left-aligned so the MSB is always the top bit of the register.
module srload_serializer #(
  parameter int WIDTH = 88,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic [CW-1:0]    i_cnt,
  input  logic             i_shift,
  output logic             o_bit,
  output logic             o_last_bit
);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shreg <= i_word;
      r_cnt   <= i_cnt;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      // Saturate at zero; only a new load moves the counter up again.
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_bit      = r_shreg[WIDTH-1];
  assign o_last_bit = (r_cnt == '0);

endmodule

// File: rtl/srload_sequencer.sv
// Arbitrates static/dynamic load requests and serialises the granted word,
// finishing each frame with a one-cycle latch pulse for the matching register.
module srload_sequencer
  import srload_pkg::*;
#(
  parameter int SIZESRSTAT = SIZESRSTAT_DEF,
  parameter int SIZESRDYN  = SIZESRDYN_DEF
) (
  input  logic     CLK,
  input  logic     RST,
  srload_if.slave  bus
);

  localparam int CW = cnt_width(SIZESRSTAT, SIZESRDYN);

  srload_state_t         r_state;
  srload_state_t         w_state_next;
  srload_grant_t         r_last_grant;

  logic                  w_pick_dyn;
  logic                  w_grant_dyn;
  logic                  w_grant_stat;
  logic                  w_load;
  logic [SIZESRSTAT-1:0] w_load_word;
  logic [CW-1:0]         w_load_cnt;
  logic                  w_shift;
  logic                  w_bit;
  logic                  w_last_bit;

  logic                  w_stat_ack;
  logic                  w_dyn_ack;
  logic                  w_sel_stat;
  logic                  w_sel_dyn;
  logic                  w_sdata;
  logic                  w_latch_stat;
  logic                  w_latch_dyn;
  logic                  w_busy;

  // On a tie the requester not served last wins; grants are suppressed during reset
  // so a request seen alongside RST is only acked once reset has gone away.
  always_comb begin
    w_pick_dyn   = bus.dyn_req && (!bus.stat_req || (r_last_grant == STAT));
    w_grant_dyn  = (r_state == IDLE) && !RST && w_pick_dyn;
    w_grant_stat = (r_state == IDLE) && !RST && bus.stat_req && !w_pick_dyn;
  end

  assign w_load      = w_grant_dyn || w_grant_stat;
  assign w_load_word = w_grant_dyn ? {bus.dyn_data, {(SIZESRSTAT-SIZESRDYN){1'b0}}}
                                   : bus.stat_data;
  assign w_load_cnt  = w_grant_dyn ? CW'(SIZESRDYN - 1) : CW'(SIZESRSTAT - 1);
  assign w_shift     = (r_state == SHIFT_DYN) || (r_state == SHIFT_STAT);

  srload_serializer #(
    .WIDTH (SIZESRSTAT),
    .CW    (CW)
  ) u_serializer (
    .clk        (CLK),
    .srst       (RST),
    .i_load     (w_load),
    .i_word     (w_load_word),
    .i_cnt      (w_load_cnt),
    .i_shift    (w_shift),
    .o_bit      (w_bit),
    .o_last_bit (w_last_bit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // last_grant also tells the LATCH state which register the finished word belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last_grant <= STAT;
    end else if (w_grant_dyn) begin
      r_last_grant <= DYN;
    end else if (w_grant_stat) begin
      r_last_grant <= STAT;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_dyn) begin
          w_state_next = SHIFT_DYN;
        end else if (w_grant_stat) begin
          w_state_next = SHIFT_STAT;
        end
      end
      SHIFT_DYN, SHIFT_STAT: begin
        if (w_last_bit) begin
          w_state_next = LATCH;
        end
      end
      LATCH:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_stat_ack   = 1'b0;
    w_dyn_ack    = 1'b0;
    w_sel_stat   = 1'b0;
    w_sel_dyn    = 1'b0;
    w_sdata      = 1'b0;
    w_latch_stat = 1'b0;
    w_latch_dyn  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_stat_ack = w_grant_stat;
        w_dyn_ack  = w_grant_dyn;
      end
      SHIFT_DYN: begin
        w_sel_dyn = 1'b1;
        w_sdata   = w_bit;
        w_busy    = 1'b1;
      end
      SHIFT_STAT: begin
        w_sel_stat = 1'b1;
        w_sdata    = w_bit;
        w_busy     = 1'b1;
      end
      LATCH: begin
        w_latch_stat = (r_last_grant == STAT);
        w_latch_dyn  = (r_last_grant == DYN);
        w_busy       = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign bus.stat_ack   = w_stat_ack;
  assign bus.dyn_ack    = w_dyn_ack;
  assign bus.SELSTAT    = w_sel_stat;
  assign bus.SELDYN     = w_sel_dyn;
  assign bus.SDATA      = w_sdata;
  assign bus.LATCH_STAT = w_latch_stat;
  assign bus.LATCH_DYN  = w_latch_dyn;
  assign bus.busy       = w_busy;

  a_sel_exclusive: assert property (@(posedge CLK) disable iff (RST)
    !(w_sel_stat && w_sel_dyn));
  a_sel_latch_exclusive: assert property (@(posedge CLK) disable iff (RST)
    !((w_sel_stat || w_sel_dyn) && (w_latch_stat || w_latch_dyn)));

endmodule

// File: doc/srload_sequencer.md
# srload_sequencer

Controller that loads the generator's static (88-bit) and dynamic (16-bit) shift registers from parallel request words. It arbitrates between a static-load requester and a dynamic-load requester, then serialises the granted word MSB-first onto one data line while asserting the matching select. It finishes each load with a one-cycle latch pulse. It sits between the uC-facing register interface and the generator, and replaces the hard-wired constant register values in the top level.

## Interface
- SIZESRSTAT, 88: static shift register length in bits.
- SIZESRDYN, 16: dynamic shift register length in bits.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- stat_req  in  1  static load request; level, held until `stat_ack`.
- stat_data  in  SIZESRSTAT  static word; sampled only on the `stat_ack` cycle.
- dyn_req  in  1  dynamic load request; level, held until `dyn_ack`.
- dyn_data  in  SIZESRDYN  dynamic word; sampled only on the `dyn_ack` cycle.
- stat_ack  out  1  one-cycle grant pulse for the static load.
- dyn_ack  out  1  one-cycle grant pulse for the dynamic load.
- SELSTAT  out  1  high while static bits are on `SDATA`.
- SELDYN  out  1  high while dynamic bits are on `SDATA`.
- SDATA  out  1  serial bit, MSB first.
- LATCH_STAT  out  1  one-cycle pulse after the last static bit.
- LATCH_DYN  out  1  one-cycle pulse after the last dynamic bit.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SHIFT_DYN, SHIFT_STAT, LATCH.
- IDLE, no request pending: stay in IDLE; all outputs 0.
- IDLE, exactly one request pending: grant it.
  - Raise the matching ack in this cycle.
  - Capture the word into the shift register.
  - Load the bit counter with N-1, where N is SIZESRDYN or SIZESRSTAT.
  - Next state is SHIFT_DYN or SHIFT_STAT.
- IDLE, both requests pending: grant the requester that was NOT granted last (`last_grant` flag).
  - After reset, `last_grant` is STAT, so dynamic wins the first tie.
  - This alternation prevents either requester from starving the other.
- SHIFT_x:
  - Drive the matching SEL high.
  - Drive `SDATA` from the shift register MSB, then shift left by one.
  - Decrement the counter.
  - When the counter reaches 0 with the last bit on the line, go to LATCH.
- LATCH:
  - All SEL low, `SDATA` 0.
  - Pulse the LATCH_x matching the word just sent.
  - Return to IDLE.
- A request raised or held while `busy` gets no ack and waits. Deasserting a request before its ack withdraws it.
- Counter is 7 bits, i.e. $clog2(max(SIZESRSTAT, SIZESRDYN)). The counter never wraps; it is reloaded only on a grant.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, counter 0, shift register 0.
  - `last_grant` = STAT.
- Grant at cycle 0, i.e. the ack cycle, in IDLE.
- Cycles 1..N: SEL high, and `SDATA` at cycle k equals data[N-k].
- Cycle N+1: LATCH_x = 1, busy = 1.
- Cycle N+2: IDLE; a new ack is possible in this same cycle.
- Frame period: dynamic 18 cycles, static 90 cycles.
- Back-to-back loads: with the next request already pending, its ack arrives at N+2. There are no dead cycles beyond LATCH.
- Reset mid-operation: on the first clock with RST=1, every output returns to 0. No LATCH pulse is issued, and the partially shifted word is discarded.
- Request asserted in the same cycle RST deasserts: not acked until the following cycle.
- SELSTAT and SELDYN are never high together. SEL and LATCH are never high together.

## Structure
- Package `srload_pkg` contains:
  - state enum `srload_state_t` (IDLE, SHIFT_DYN, SHIFT_STAT, LATCH);
  - grant enum (DYN, STAT);
  - default constants for SIZESRSTAT and SIZESRDYN;
  - counter width constant.
- One sub-module, `srload_serializer`:
  - SIZESRSTAT-wide shift register plus down-counter;
  - load port: word left-aligned, counter preset;
  - shift-enable input;
  - `last_bit` flag output.
- The dynamic word is left-aligned into the same register; there is no second shifter.
- The arbiter and FSM stay in `srload_sequencer`.

## Test plan
- After reset, `dyn_req` with 16'h1234 -> `dyn_ack` at cycle 0; `SDATA` cycles 1..16 = 0001_0010_0011_0100; `LATCH_DYN` at cycle 17; `busy` low at cycle 18.
- `stat_req` with 88'hABCDEF123456789ABCDEF1 -> `SELSTAT` high for cycles 1..88; first bits 1,0,1,0; last bits 0,0,0,1; `LATCH_STAT` at cycle 89.
- Both requests rise together after reset -> dynamic granted first, static acked at cycle 18, static `LATCH_STAT` at cycle 107.
- `dyn_req` held high continuously with `stat_req` high -> grants alternate DYN, STAT, DYN. Each ack follows the previous LATCH by exactly one cycle.
- RST pulsed on cycle 6 of a static shift -> next cycle all outputs 0. No `LATCH_STAT` is seen. A fresh static request afterwards re-sends all 88 bits from the MSB.
- `dyn_req` raised during a static frame and dropped before its LATCH -> no `dyn_ack`; `busy` falls at N+2.
